// File: rtl/ex_mdu_seq_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer.
package ex_mdu_seq_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;

   localparam logic [7:0] ALUOP_DIV   = 8'b00011010;
   localparam logic [7:0] ALUOP_DIVU  = 8'b00011011;
   localparam logic [7:0] ALUOP_MADD  = 8'b10100110;
   localparam logic [7:0] ALUOP_MADDU = 8'b10101000;
   localparam logic [7:0] ALUOP_MSUB  = 8'b10101010;
   localparam logic [7:0] ALUOP_MSUBU = 8'b10101011;

   localparam logic [DATA_W-1:0] DIV_ZERO_LO = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIV_RUN  = 2'd1,
      ST_DIV_DONE = 2'd2,
      ST_MAC_ACC  = 2'd3
   } mdu_state_e;

   // Magnitude of a value when treated as signed; raw value otherwise.
   function automatic logic [DATA_W-1:0] mag(input logic is_signed,
                                             input logic [DATA_W-1:0] v);
      return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
   endfunction

endpackage

// File: rtl/ex_mdu_seq_div_step.sv
// One restoring-division step: trial-subtract divisor from {rem, next bit}.
module ex_mdu_seq_div_step
   import ex_mdu_seq_pkg::*;
(
   input  logic [DATA_W:0]   i_rem,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [DATA_W-1:0] o_rem,
   output logic              o_quot
);

   logic [DATA_W:0] w_diff;

   // Remainder stays below the divisor, so the difference fits DATA_W bits.
   always_comb begin
      w_diff = i_rem - {1'b0, i_divisor};
      o_quot = (i_rem >= {1'b0, i_divisor});
      o_rem  = o_quot ? w_diff[DATA_W-1:0] : i_rem[DATA_W-1:0];
   end

endmodule

// File: rtl/ex_mdu_seq.sv
// Multi-cycle DIV/DIVU sequencer and MADD/MSUB accumulate path beside EX.
// Optional feature macro: MDU_MAC_EN (enables MADD/MADDU/MSUB/MSUBU sequencing).
module ex_mdu_seq
   import ex_mdu_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          aluop_i,
   input  logic [DATA_W-1:0]   reg1_i,
   input  logic [DATA_W-1:0]   reg2_i,
   input  logic [2*DATA_W-1:0] mul_res_i,
   input  logic [DATA_W-1:0]   hi_i,
   input  logic [DATA_W-1:0]   lo_i,
   input  logic                stall_i,
   input  logic                annul_i,
   output logic                stallreq_o,
   output logic                whilo_o,
   output logic [DATA_W-1:0]   hi_o,
   output logic [DATA_W-1:0]   lo_o
);

   mdu_state_e        r_state;
   mdu_state_e        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvd;      // dividend shifts out MSB first, quotient shifts in
   logic [DATA_W-1:0] r_dvs;
   logic              r_zero;
   logic              r_neg_q;
   logic              r_neg_r;

   logic              w_is_div;
   logic              w_is_signed;
   logic              w_is_mac;
   logic              w_start_div;
   logic              w_start_mac;
   logic              w_dvs_zero;
   logic [DATA_W-1:0] w_step_rem;
   logic              w_step_q;

   assign w_is_div    = (aluop_i == ALUOP_DIV) || (aluop_i == ALUOP_DIVU);
   assign w_is_signed = (aluop_i == ALUOP_DIV);
   assign w_dvs_zero  = (reg2_i == '0);

`ifdef MDU_MAC_EN
   logic [2*DATA_W-1:0] r_prod;
   logic                r_sub;
   logic                w_mac_sub;
   logic [2*DATA_W-1:0] w_acc;
   logic [2*DATA_W-1:0] w_mac_res;

   assign w_is_mac  = (aluop_i == ALUOP_MADD) || (aluop_i == ALUOP_MADDU) ||
                      (aluop_i == ALUOP_MSUB) || (aluop_i == ALUOP_MSUBU);
   assign w_mac_sub = (aluop_i == ALUOP_MSUB) || (aluop_i == ALUOP_MSUBU);
   assign w_acc     = {hi_i, lo_i};
   assign w_mac_res = r_sub ? (w_acc - r_prod) : (w_acc + r_prod);
`else
   logic w_unused_mac;
   assign w_is_mac     = 1'b0;
   assign w_unused_mac = ^{mul_res_i, hi_i, lo_i};
`endif

   ex_mdu_seq_div_step u_div_step (
      .i_rem     ({r_rem, r_dvd[DATA_W-1]}),
      .i_divisor (r_dvs),
      .o_rem     (w_step_rem),
      .o_quot    (w_step_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, stall request and HI/LO write port.
   always_comb begin
      w_state_nxt = r_state;
      stallreq_o  = 1'b0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
      w_start_div = 1'b0;
      w_start_mac = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_div) begin
               stallreq_o  = 1'b1;
               w_start_div = 1'b1;
               w_state_nxt = w_dvs_zero ? ST_DIV_DONE : ST_DIV_RUN;
            end else if (w_is_mac) begin
               stallreq_o  = 1'b1;
               w_start_mac = 1'b1;
               w_state_nxt = ST_MAC_ACC;
            end
         end
         ST_DIV_RUN: begin
            stallreq_o = 1'b1;
            if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = ST_DIV_DONE;
         end
         ST_DIV_DONE: begin
            whilo_o = 1'b1;
            if (r_zero) begin
               lo_o = DIV_ZERO_LO;
               hi_o = r_rem;
            end else begin
               lo_o = r_neg_q ? DATA_W'(-r_dvd) : r_dvd;
               hi_o = r_neg_r ? DATA_W'(-r_rem) : r_rem;
            end
            if (!stall_i) w_state_nxt = ST_IDLE;
         end
`ifdef MDU_MAC_EN
         ST_MAC_ACC: begin
            whilo_o = 1'b1;
            hi_o    = w_mac_res[2*DATA_W-1:DATA_W];
            lo_o    = w_mac_res[DATA_W-1:0];
            if (!stall_i) w_state_nxt = ST_IDLE;
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
      // Reset and flush kill the request and the write in the same cycle.
      if (rst || annul_i) begin
         w_state_nxt = ST_IDLE;
         stallreq_o  = 1'b0;
         whilo_o     = 1'b0;
         hi_o        = '0;
         lo_o        = '0;
         w_start_div = 1'b0;
         w_start_mac = 1'b0;
      end
   end

   // Divider operand latch and per-cycle restoring iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_zero  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (annul_i) begin
         r_cnt <= '0;
      end else if (w_start_div) begin
         r_dvd   <= mag(w_is_signed, reg1_i);
         r_dvs   <= mag(w_is_signed, reg2_i);
         r_rem   <= w_dvs_zero ? reg1_i : '0;
         r_zero  <= w_dvs_zero;
         r_neg_q <= w_is_signed & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
         r_neg_r <= w_is_signed & reg1_i[DATA_W-1];
         r_cnt   <= '0;
      end else if (r_state == ST_DIV_RUN) begin
         r_rem <= w_step_rem;
         r_dvd <= {r_dvd[DATA_W-2:0], w_step_q};
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifdef MDU_MAC_EN
   // Product and add/sub direction captured when a MAC op enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod <= '0;
         r_sub  <= 1'b0;
      end else if (w_start_mac) begin
         r_prod <= mul_res_i;
         r_sub  <= w_mac_sub;
      end
   end
`endif

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Scoreboard bench for ex_mdu_seq: directed divide / MAC / flush / hold / reset vectors.
module tb_ex_mdu_seq;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_DIV   = 8'b00011010;
   localparam logic [7:0] OP_DIVU  = 8'b00011011;
   localparam logic [7:0] OP_MADD  = 8'b10100110;
   localparam logic [7:0] OP_MADDU = 8'b10101000;
   localparam logic [7:0] OP_MSUB  = 8'b10101010;
   localparam logic [7:0] OP_MSUBU = 8'b10101011;

`ifdef MDU_MAC_EN
   localparam int MAC_ST   = 1;
   localparam bit MAC_PUSH = 1'b1;
`else
   localparam int MAC_ST   = 0;
   localparam bit MAC_PUSH = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
   logic [63:0] mul_res_i;
   logic        stall_i, annul_i;
   logic        stallreq_o, whilo_o;
   logic [31:0] hi_o, lo_o;

   int          n_checks;
   int          n_fails;
   logic [63:0] exp_q[$];

   ex_mdu_seq dut (
      .clk        (clk),
      .rst        (rst),
      .aluop_i    (aluop_i),
      .reg1_i     (reg1_i),
      .reg2_i     (reg2_i),
      .mul_res_i  (mul_res_i),
      .hi_i       (hi_i),
      .lo_i       (lo_i),
      .stall_i    (stall_i),
      .annul_i    (annul_i),
      .stallreq_o (stallreq_o),
      .whilo_o    (whilo_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every HI/LO write is compared with the head of the scoreboard;
   // the entry retires only when the write is consumed (no downstream stall).
   always @(negedge clk) begin
      if (whilo_o) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_whilo: got hi=%h lo=%h, required no write", hi_o, lo_o);
         end else begin
            if ({hi_o, lo_o} !== exp_q[0]) begin
               n_fails++;
               $display("FAIL hilo: got hi=%h lo=%h, required hi=%h lo=%h",
                        hi_o, lo_o, exp_q[0][63:32], exp_q[0][31:0]);
            end
            if (!stall_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic check_idle(input string name);
      n_checks++;
      if (stallreq_o !== 1'b0 || whilo_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
         n_fails++;
         $display("FAIL %s: got stallreq=%b whilo=%b hi=%h lo=%h, required all zero",
                  name, stallreq_o, whilo_o, hi_o, lo_o);
      end
   endtask

   // Issue one op, count stall-request cycles, optionally hold the result.
   task automatic run_op(input string name, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] mul, input logic [31:0] hi, input logic [31:0] lo,
                         input int exp_stall, input int hold,
                         input bit push, input logic [63:0] exp);
      int  n;
      bit  done;
      if (push) exp_q.push_back(exp);
      aluop_i   = op;
      reg1_i    = a;
      reg2_i    = b;
      mul_res_i = mul;
      hi_i      = 32'hDEADBEEF;
      lo_i      = 32'hDEADBEEF;
      stall_i   = (hold > 0);
      n    = 0;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (stallreq_o) begin
            n++;
            @(posedge clk); #1;
            hi_i = hi;
            lo_i = lo;
         end else begin
            done = 1'b1;
         end
      end
      n_checks++;
      if (!done) begin
         n_fails++;
         $display("FAIL %s_timeout: stallreq still high after 64 cycles, required release", name);
      end else if (n != exp_stall) begin
         n_fails++;
         $display("FAIL %s_stall_cycles: got %0d, required %0d", name, n, exp_stall);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (h == hold - 1) stall_i = 1'b0;
         @(negedge clk);
         n_checks++;
         if (whilo_o !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_hold_whilo: got %b, required 1", name, whilo_o);
         end
      end
      @(posedge clk); #1;
      aluop_i = OP_NOP;
      stall_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      rst       = 1'b1;
      aluop_i   = OP_NOP;
      reg1_i    = '0;
      reg2_i    = '0;
      mul_res_i = '0;
      hi_i      = '0;
      lo_i      = '0;
      stall_i   = 1'b0;
      annul_i   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("in_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle_nop");
      @(posedge clk); #1;

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, '0, '0, '0, 33, 0, 1'b1, {32'd2, 32'd14});
      run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, '0, '0, '0, 33, 0, 1'b1,
             {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, '0, '0, '0, 33, 0, 1'b1,
             {32'd1, 32'hFFFFFFFD});
      run_op("div_m8_m3", OP_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, '0, '0, '0, 33, 0, 1'b1,
             {32'hFFFFFFFE, 32'd2});
      run_op("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, '0, '0, '0, 33, 0, 1'b1,
             {32'd0, 32'hFFFFFFFF});
      run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, '0, '0, '0, 33, 0, 1'b1,
             {32'd0, 32'h80000000});
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, '0, '0, '0, 1, 0, 1'b1, {32'd5, 32'hFFFFFFFF});
      run_op("div_m7_0", OP_DIV, 32'hFFFFFFF9, 32'd0, '0, '0, '0, 1, 0, 1'b1,
             {32'hFFFFFFF9, 32'hFFFFFFFF});

      run_op("maddu", OP_MADDU, 32'd1, 32'd1, 64'd1, 32'h0, 32'hFFFFFFFF, MAC_ST, 0, MAC_PUSH,
             {32'd1, 32'd0});
      run_op("msubu", OP_MSUBU, 32'd2, 32'd3, 64'd6, 32'h0, 32'h0, MAC_ST, 0, MAC_PUSH,
             {32'hFFFFFFFF, 32'hFFFFFFFA});
      run_op("madd", OP_MADD, 32'd3, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFA, 32'h0, 32'h10, MAC_ST, 0,
             MAC_PUSH, {32'd0, 32'hA});
      run_op("msub", OP_MSUB, 32'd1, 32'd1, 64'd1, 32'h0, 32'h0, MAC_ST, 0, MAC_PUSH,
             {32'hFFFFFFFF, 32'hFFFFFFFF});

      // Flush mid-divide at cycle 10.
      aluop_i = OP_DIVU;
      reg1_i  = 32'd100;
      reg2_i  = 32'd7;
      repeat (10) begin
         @(posedge clk); #1;
      end
      annul_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
         n_fails++;
         $display("FAIL flush_cycle: got stallreq=%b whilo=%b, required 0 0", stallreq_o, whilo_o);
      end
      @(posedge clk); #1;
      annul_i = 1'b0;
      aluop_i = OP_NOP;
      @(negedge clk);
      check_idle("after_flush");
      @(posedge clk); #1;
      run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, '0, '0, '0, 33, 0, 1'b1, {32'd0, 32'd3});

      run_op("divu_hold", OP_DIVU, 32'd100, 32'd7, '0, '0, '0, 33, 3, 1'b1, {32'd2, 32'd14});

      // Synchronous reset at cycle 5 of a divide.
      aluop_i = OP_DIVU;
      reg1_i  = 32'd100;
      reg2_i  = 32'd7;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      aluop_i = OP_NOP;
      @(negedge clk);
      check_idle("post_reset");
      @(posedge clk); #1;
      run_op("div_after_rst", OP_DIV, 32'hFFFFFFF9, 32'd2, '0, '0, '0, 33, 0, 1'b1,
             {32'hFFFFFFFF, 32'hFFFFFFFD});

      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/ex_mdu_seq.md
# ex_mdu_seq

Multi-cycle multiply/divide sequencer beside the EX stage. Owns an iterative restoring divider and the two-cycle MADD/MSUB accumulate path, raises a stall request to the pipeline controller while busy, and drives the HI/LO write port into EX/MEM. When its HI/LO write is active, it overrides the EX stage's own HI/LO write (mthi, mtlo, mult).

## Interface
- DATA_W, 32, operand/HI/LO width; only 32 is supported.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- aluop_i  in  8  EX opcode.
  - DIV 8'b00011010, DIVU 8'b00011011.
  - MADD 8'b10100110, MADDU 8'b10101000.
  - MSUB 8'b10101010, MSUBU 8'b10101011.
- reg1_i  in  DATA_W  dividend / multiplicand (forwarded).
- reg2_i  in  DATA_W  divisor / multiplier (forwarded).
- mul_res_i  in  2*DATA_W  64-bit product from the EX multiplier; signed for MADD/MSUB, unsigned for MADDU/MSUBU.
- hi_i, lo_i  in  DATA_W  forwarded current HI/LO.
- stall_i  in  1  downstream stall; the instruction in EX is held.
- annul_i  in  1  flush of the EX instruction.
- stallreq_o  out  1  hold IF..EX.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  DATA_W  HI/LO write data.

## Operation
- States: IDLE, DIV_RUN, DIV_DONE, MAC_ACC.
- Reset: state IDLE; counter 0; all outputs 0.

IDLE, non-MDU opcode:
- stallreq_o=0, whilo_o=0, hi_o=lo_o=0.

IDLE, DIV/DIVU:
- stallreq_o=1 combinationally.
- Latch |dividend| and |divisor| (magnitudes for DIV, raw values for DIVU), plus both sign bits.
- Divisor==0: go to DIV_DONE with the zero flag set.
- Otherwise: go to DIV_RUN, counter=0.

DIV_RUN:
- stallreq_o=1.
- One quotient bit per cycle, MSB first.
- Leave after counter==31 → DIV_DONE.

DIV_DONE:
- stallreq_o=0, whilo_o=1.
- lo_o = quotient, negated if DIV and the operand signs differ.
- hi_o = remainder, negated if DIV and the dividend was negative.
- Divide by zero: lo_o=32'hFFFFFFFF, hi_o = raw dividend.
- stall_i=1: stay in DIV_DONE and hold outputs. Otherwise → IDLE.

IDLE, MADD*/MSUB* (MDU_MAC_EN only):
- stallreq_o=1.
- Latch mul_res_i and the add/sub flag → MAC_ACC.

MAC_ACC:
- stallreq_o=0, whilo_o=1.
- {hi_o,lo_o} = {hi_i,lo_i} ± latched product, 64-bit modulo, no overflow trap.
- hi_i/lo_i are sampled in this cycle, so an older HI/LO writer forwarded via EX is honoured.
- stall_i=1: stay and hold. Otherwise → IDLE.

annul_i=1 in any state:
- stallreq_o=0 and whilo_o=0 in the same cycle.
- Next state IDLE, counter cleared.
- A partial divide is discarded.

stall_i in DIV_RUN:
- Iteration continues; only DIV_DONE and MAC_ACC wait on it.

Priority:
- rst > annul_i > normal operation.

## Timing
- Cycle 0 = first cycle the opcode is in EX.
- DIV/DIVU, nonzero divisor:
  - stallreq_o high in cycles 0..32.
  - whilo_o=1 in cycle 33.
  - EX advances at the end of cycle 33 (absent stall_i).
- Divide by zero: stallreq_o high in cycle 0 only; result in cycle 1.
- MADD/MSUB: stallreq_o high in cycle 0; result in cycle 1.
- IDLE re-entry: the opcode in EX at the cycle after DIV_DONE/MAC_ACC belongs to a new instruction, so back-to-back MDU ops restart cleanly.
- Outputs:
  - hi_o/lo_o/whilo_o are combinational from state and registers; valid only in DIV_DONE/MAC_ACC.
  - stallreq_o is combinational from state and aluop_i.

## Configuration
- MDU_MAC_EN defined: MADD/MADDU/MSUB/MSUBU are sequenced as above, MAC_ACC exists, and mul_res_i is used.
- MDU_MAC_EN undefined:
  - MAC_ACC and the product register are removed.
  - The MAC opcodes behave as non-MDU (no stall, no write).
  - mul_res_i is ignored.

## Structure
- Shared package / defines.v:
  - aluop codes for DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
  - State encoding constants.
  - DIV_ZERO_LO constant (32'hFFFFFFFF).
- Sub-module div_step: combinational one-bit restoring step.
  - Inputs: partial remainder {rem, next dividend bit} and divisor.
  - Outputs: next remainder and quotient bit.
  - Instantiated once; the sequencer holds the rem/quot/counter registers.

## Test plan
- DIVU 100/7:
  - stallreq_o high exactly 33 cycles.
  - Cycle 33: whilo_o=1, lo_o=14, hi_o=2.
- DIV -7/2 (32'hFFFFFFF9 / 2): lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF.
- DIVU 5/0:
  - stallreq_o high 1 cycle.
  - Cycle 1: lo_o=32'hFFFFFFFF, hi_o=5.
- MADDU 1×1 with HI:LO=0:FFFFFFFF → hi_o=1, lo_o=0.
- MSUBU 2×3 from 0:0 → hi_o=FFFFFFFF, lo_o=FFFFFFFA.
- Flush mid-divide: annul_i at cycle 10 of DIVU 100/7.
  - stallreq_o=0 that cycle; whilo_o never asserted.
  - A following DIVU 9/3 gives lo_o=3, hi_o=0.
- Hold and reset:
  - stall_i high 3 cycles in DIV_DONE → outputs stable and whilo_o held.
  - rst at cycle 5 of a divide → IDLE, all outputs 0 next cycle.
